// File: rtl/riscv_v_exe_sequencer.sv
// rtl/riscv_v_exe_sequencer.sv - vector execute issue/completion sequencer

package riscv_v_exe_sequencer_pkg;
   // Vector length as carried down the decode pipeline.
   typedef logic [7:0] riscv_v_vl_t;
endpackage

module riscv_v_exe_sequencer
   import riscv_v_exe_sequencer_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 3,
   parameter int unsigned RED_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid,
   output logic        dec_ready,
   input  logic        is_mul_dec,
   input  logic        is_reduct_dec,
   input  logic        is_v2i_dec,
   input  riscv_v_vl_t vl_dec,
   input  logic        flush,
   output logic        exe_load,
   output logic        alu_hold,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic        wb_vec_we,
   output logic        wb_int_we,
   output logic        busy,
   output logic [31:0] retired_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);
   localparam logic [3:0] RED_LAT = 4'(RED_LATENCY);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        v2i_q, v2i_d;
   logic        vl_zero_q, vl_zero_d;
   logic [31:0] retired_q, retired_d;
   logic [3:0]  lat;
   logic        accept;

   // Handshake towards decode; reset and flush both block acceptance.
   always_comb begin
      dec_ready = ~rst & ~flush &
                  ((state_q == IDLE) | ((state_q == DONE) & wb_ready));
      accept    = dec_valid & dec_ready;
      exe_load  = accept;
      if (is_reduct_dec) begin
         lat = RED_LAT;
      end else if (is_mul_dec) begin
         lat = MUL_LAT;
      end else begin
         lat = 4'd1;
      end
   end

   // Next-state logic: issue, countdown, writeback completion and flush.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      v2i_d     = v2i_q;
      vl_zero_d = vl_zero_q;
      retired_d = retired_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: ;
            EXEC: begin
               if (cnt_q == 4'd0) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            DONE: begin
               if (wb_ready) begin
                  retired_d = retired_q + 32'd1;
                  state_d   = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
         // A new instruction overrides the IDLE return so DONE->issue has no bubble.
         if (accept) begin
            v2i_d     = is_v2i_dec;
            vl_zero_d = (vl_dec == '0);
            if (lat == 4'd1) begin
               state_d = DONE;
            end else begin
               state_d = EXEC;
               cnt_d   = lat - 4'd2;
            end
         end
      end
   end

   // State and latched instruction fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         v2i_q     <= 1'b0;
         vl_zero_q <= 1'b0;
         retired_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         v2i_q     <= v2i_d;
         vl_zero_q <= vl_zero_d;
         retired_q <= retired_d;
      end
   end

   // Outputs decoded from registered state only, so nothing reaches wb_* from decode.
   always_comb begin
      busy        = (state_q != IDLE);
      alu_hold    = (state_q == EXEC) | (state_q == DONE);
      wb_valid    = (state_q == DONE);
      wb_vec_we   = wb_valid & ~v2i_q & ~vl_zero_q;
      wb_int_we   = wb_valid & v2i_q;
      retired_cnt = retired_q;
   end

endmodule

// File: tb/tb_riscv_v_exe_sequencer.sv
// tb/tb_riscv_v_exe_sequencer.sv - directed bench with writeback scoreboard

module tb_riscv_v_exe_sequencer;
   import riscv_v_exe_sequencer_pkg::*;

   localparam int MUL_LAT = 3;
   localparam int RED_LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid, dec_ready;
   logic        is_mul_dec, is_reduct_dec, is_v2i_dec;
   riscv_v_vl_t vl_dec;
   logic        flush;
   logic        exe_load, alu_hold, wb_valid, wb_ready;
   logic        wb_vec_we, wb_int_we, busy;
   logic [31:0] retired_cnt;

   riscv_v_exe_sequencer #(.MUL_LATENCY(MUL_LAT), .RED_LATENCY(RED_LAT)) dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .is_mul_dec(is_mul_dec), .is_reduct_dec(is_reduct_dec),
      .is_v2i_dec(is_v2i_dec), .vl_dec(vl_dec), .flush(flush),
      .exe_load(exe_load), .alu_hold(alu_hold), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_vec_we(wb_vec_we), .wb_int_we(wb_int_we),
      .busy(busy), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic vec_we;
      logic int_we;
      int   due;
   } sb_t;

   sb_t         sb_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          cyc    = 0;
   logic        head_seen = 1'b0;
   logic [31:0] exp_ret = 0;
   logic [31:0] ret_off = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push on accept, check latency and enables on writeback, pop on retire/flush.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sb_q.delete();
         head_seen = 1'b0;
         exp_ret   = 0;
      end else begin
         chk("sb_retired", retired_cnt, exp_ret + ret_off);
         if (wb_valid) begin
            if (!head_seen) begin
               chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
               if (sb_q.size() != 0) chk("sb_latency", cyc, sb_q[0].due);
               head_seen = 1'b1;
            end
            if (sb_q.size() != 0) begin
               chk("sb_vec_we", 32'(wb_vec_we), 32'(sb_q[0].vec_we));
               chk("sb_int_we", 32'(wb_int_we), 32'(sb_q[0].int_we));
            end
         end
         if (flush) begin
            if (busy && sb_q.size() != 0) void'(sb_q.pop_front());
            head_seen = 1'b0;
         end else if (wb_valid && wb_ready) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            exp_ret++;
            head_seen = 1'b0;
         end
         if (exe_load) begin
            sb_t e;
            e.vec_we = ~is_v2i_dec & (vl_dec != 0);
            e.int_we = is_v2i_dec;
            e.due    = cyc + (is_reduct_dec ? RED_LAT : (is_mul_dec ? MUL_LAT : 1));
            sb_q.push_back(e);
         end
      end
   end

   initial begin
      rst = 1'b1; dec_valid = 0; is_mul_dec = 0; is_reduct_dec = 0; is_v2i_dec = 0;
      vl_dec = 8'd0; flush = 0; wb_ready = 0;
      #2;
      chk("rst_dec_ready", 32'(dec_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wb_valid", 32'(wb_valid), 0);
      chk("rst_alu_hold", 32'(alu_hold), 0);
      chk("rst_retired", retired_cnt, 0);
      step(); step(); rst = 1'b0; #2;
      chk("post_rst_ready", 32'(dec_ready), 1);

      // simple op
      step(); wb_ready = 1; dec_valid = 1; vl_dec = 8'd5; #2;
      chk("simple_exe_load", 32'(exe_load), 1);
      step(); dec_valid = 0; #2;
      chk("simple_wb_valid", 32'(wb_valid), 1);
      chk("simple_vec_we", 32'(wb_vec_we), 1);
      chk("simple_int_we", 32'(wb_int_we), 0);
      step(); #2;
      chk("simple_retired", retired_cnt, 1);
      chk("simple_idle", 32'(busy), 0);

      // multiply then back-to-back v2i simple op
      step(); dec_valid = 1; is_mul_dec = 1; vl_dec = 8'd3; #2;
      chk("mul_exe_load", 32'(exe_load), 1);
      step(); is_mul_dec = 0; is_v2i_dec = 1; #2;
      chk("mul_t1_ready", 32'(dec_ready), 0);
      chk("mul_t1_hold", 32'(alu_hold), 1);
      chk("mul_t1_wb", 32'(wb_valid), 0);
      step(); #2;
      chk("mul_t2_ready", 32'(dec_ready), 0);
      chk("mul_t2_hold", 32'(alu_hold), 1);
      step(); #2;
      chk("mul_t3_wb", 32'(wb_valid), 1);
      chk("mul_t3_b2b_load", 32'(exe_load), 1);
      step(); dec_valid = 0; is_v2i_dec = 0; #2;
      chk("b2b_wb_valid", 32'(wb_valid), 1);
      chk("b2b_int_we", 32'(wb_int_we), 1);
      step(); #2;
      chk("b2b_retired", retired_cnt, 3);

      // reduction with both class bits, writeback backpressure
      step(); wb_ready = 0; dec_valid = 1; is_mul_dec = 1; is_reduct_dec = 1; #2;
      chk("red_exe_load", 32'(exe_load), 1);
      step(); dec_valid = 0; is_mul_dec = 0; is_reduct_dec = 0; #2;
      for (int i = 0; i < 2; i++) begin
         step(); #2;
      end
      chk("red_t3_wb", 32'(wb_valid), 0);
      for (int i = 0; i < 5; i++) begin
         step(); #2;
         chk("bp_wb_valid", 32'(wb_valid), 1);
         chk("bp_dec_ready", 32'(dec_ready), 0);
      end
      step(); wb_ready = 1; #2;
      chk("bp_t9_ready", 32'(dec_ready), 1);
      step(); #2;
      chk("bp_idle", 32'(busy), 0);
      chk("bp_retired", retired_cnt, 4);

      // vl == 0, vector then v2i
      step(); dec_valid = 1; vl_dec = 8'd0; #2;
      step(); is_v2i_dec = 1; #2;
      chk("vl0_vec_valid", 32'(wb_valid), 1);
      chk("vl0_vec_we", 32'(wb_vec_we), 0);
      step(); dec_valid = 0; is_v2i_dec = 0; vl_dec = 8'd1; #2;
      chk("vl0_int_we", 32'(wb_int_we), 1);
      chk("vl0_int_vec_we", 32'(wb_vec_we), 0);

      // sustained simple throughput
      step(); dec_valid = 1; vl_dec = 8'd8; #2;
      for (int i = 0; i < 3; i++) begin
         step(); #2;
         chk("tput_load", 32'(exe_load), 1);
         chk("tput_wb", 32'(wb_valid), 1);
      end
      step(); dec_valid = 0; #2;
      step(); #2;
      chk("tput_retired", retired_cnt, 10);

      // flush during EXEC
      step(); dec_valid = 1; is_mul_dec = 1; #2;
      step(); dec_valid = 0; is_mul_dec = 0; flush = 1; #2;
      chk("flx_ready", 32'(dec_ready), 0);
      step(); flush = 0; #2;
      chk("flx_idle", 32'(busy), 0);
      for (int i = 0; i < 3; i++) begin
         step(); #2;
         chk("flx_no_wb", 32'(wb_valid), 0);
      end

      // flush in DONE alongside wb_ready, with a pending decode
      step(); dec_valid = 1; #2;
      step(); flush = 1; #2;
      chk("fld_wb", 32'(wb_valid), 1);
      chk("fld_no_load", 32'(exe_load), 0);
      step(); dec_valid = 0; flush = 0; #2;
      chk("fld_idle", 32'(busy), 0);
      chk("fld_retired", retired_cnt, 10);

      // asynchronous reset mid reduction
      step(); dec_valid = 1; is_reduct_dec = 1; #2;
      step(); dec_valid = 0; is_reduct_dec = 0; #1; rst = 1; #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_hold", 32'(alu_hold), 0);
      chk("arst_ready", 32'(dec_ready), 0);
      chk("arst_retired", retired_cnt, 0);
      step(); rst = 0; #2;
      chk("arst_release_ready", 32'(dec_ready), 1);

      // retired counter wrap
      step();
      force dut.retired_q = 32'hFFFF_FFFF;
      ret_off = 32'hFFFF_FFFF - exp_ret;
      #1 release dut.retired_q;
      dec_valid = 1; #1;
      chk("wrap_pre", retired_cnt, 32'hFFFF_FFFF);
      step(); dec_valid = 0; #2;
      step(); #2;
      chk("wrap_zero", retired_cnt, 0);

      step(); #2;
      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
